muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Sequencer for the iterative multiply and divide units of the multicycle MIPS core.
//  Latches operands, pulses a unit-local clear, then enables one unit for a fixed cycle count.
//  Captures the unit's hi/lo pair into architectural HI/LO and stalls mfhi/mflo and new mult/div while busy.
//  Sits between the main control FSM and the mult/div datapath units.
// PARAMETERS
//  WIDTH        32  operand / HI / LO width
//  MULT_CYCLES  32  RUN-state cycles granted to the multiplier (>=1)
//  DIV_CYCLES   32  RUN-state cycles granted to the divider (>=1)
//  CNT_W        6   RUN counter width; must hold max(MULT_CYCLES,DIV_CYCLES)
// PORTS
//  clk         in   1      clock, all state on rising edge
//  reset       in   1      synchronous, active-high
//  start_mult  in   1      request signed multiply op_a*op_b (level, sampled in IDLE)
//  start_div   in   1      request signed divide op_a/op_b (level, sampled in IDLE)
//  op_a        in   WIDTH  operand A (rs)
//  op_b        in   WIDTH  operand B (rt)
//  mfhi_req    in   1      control wants HI this cycle
//  mflo_req    in   1      control wants LO this cycle
//  mult_hi     in   WIDTH  multiplier result, upper half
//  mult_lo     in   WIDTH  multiplier result, lower half
//  div_hi      in   WIDTH  divider remainder
//  div_lo      in   WIDTH  divider quotient
//  unit_rst    out  1      clear pulse to the selected unit (high only in CLR)
//  mult_en     out  1      multiplier clock enable (high only in RUN with op=mult)
//  div_en      out  1      divider clock enable (high only in RUN with op=div)
//  opnd_a      out  WIDTH  latched operand A, stable from CLR through WB
//  opnd_b      out  WIDTH  latched operand B, stable from CLR through WB
//  hi_out      out  WIDTH  architectural HI register
//  lo_out      out  WIDTH  architectural LO register
//  busy        out  1      state != IDLE
//  stall       out  1      busy & (mfhi_req|mflo_req|start_mult|start_div), combinational
//  done        out  1      one-cycle pulse in WB
//  div_zero    out  1      sticky: last divide had op_b==0; cleared by next accepted start
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, HI=LO=0, opnd_a/b=0, div_zero=0; all 1-bit outputs 0. Reset wins over every other event.
//  States: IDLE, CLR, RUN, WB.
//  IDLE: start_mult -> latch op_a/op_b, op=mult, clear div_zero, go CLR.
//   start_div with op_b!=0 -> latch, op=div, clear div_zero, go CLR.
//   start_div with op_b==0 -> set div_zero, go WB with write suppressed; HI/LO unchanged.
//   start_mult and start_div in the same cycle: mult accepted, div dropped.
//  CLR: unit_rst=1 for exactly one cycle; cnt<=0; go RUN.
//  RUN: selected enable=1; cnt<=cnt+1. Leave for WB on the cycle cnt==N-1 (N=MULT_CYCLES or DIV_CYCLES), so RUN lasts exactly N cycles.
//  WB: done=1. HI<=sel_hi and LO<=sel_lo on this edge unless suppressed. Go IDLE.
//  Latency: start sampled at edge E -> CLR at E+1, RUN through E+N+1, WB at E+N+2 -> IDLE with new HI/LO after edge E+N+2 (N+2 busy cycles).
//  Starts arriving while busy are ignored, not queued; stall tells control to hold them.
//  mfhi/mflo in IDLE: no stall; hi_out/lo_out give the current registers.
//  Reset mid-RUN: IDLE next edge, HI/LO=0; the partial unit result is never captured.
// TESTING
//  start_mult, op_a=7, op_b=-3, mock unit returning FFFFFFFF/FFFFFFEB -> unit_rst 1 cycle, mult_en exactly 32 cycles, done pulse, HI=FFFFFFFF, LO=FFFFFFEB, busy high 34 cycles.
//  start_div op_a=17 op_b=5, mock 2/3 -> div_en 32 cycles, HI=2, LO=3, div_zero=0.
//  start_div op_b=0 after prior HI=2/LO=3 -> no unit_rst/div_en, done after 1 cycle, div_zero=1, HI/LO still 2/3.
//  start_mult & start_div same cycle -> only mult_en ever asserts; next start clears div_zero.
//  mfhi_req during RUN -> stall=1 every busy cycle; stall=0 and hi_out updated on the cycle after WB.
//  reset at RUN cycle 10 -> IDLE next edge, HI=LO=0, busy=0, no done; new start_mult also ignored while busy.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the iterative mult/div units.
// Latches operands, clears and runs one unit, then writes HI/LO.
module muldiv_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mfhi_req,
  input  logic             mflo_req,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  output logic             unit_rst,
  output logic             mult_en,
  output logic             div_en,
  output logic [WIDTH-1:0] opnd_a,
  output logic [WIDTH-1:0] opnd_b,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_WB
  } state_e;

  localparam logic [CNT_W-1:0] MULT_LAST =
    CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST =
    CNT_W'(DIV_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             op_div_q;
  logic             wr_q;
  logic             unit_rst_q;
  logic             mult_en_q;
  logic             div_en_q;
  logic             busy_q;
  logic             done_q;
  logic             div_zero_q;
  logic [WIDTH-1:0] opnd_a_q;
  logic [WIDTH-1:0] opnd_b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [CNT_W-1:0] last_d;
  logic [WIDTH-1:0] sel_hi_d;
  logic [WIDTH-1:0] sel_lo_d;

  assign last_d   = op_div_q ? DIV_LAST : MULT_LAST;
  assign sel_hi_d = op_div_q ? div_hi : mult_hi;
  assign sel_lo_d = op_div_q ? div_lo : mult_lo;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_div_q   <= 1'b0;
      wr_q       <= 1'b0;
      unit_rst_q <= 1'b0;
      mult_en_q  <= 1'b0;
      div_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      opnd_a_q   <= '0;
      opnd_b_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_mult) begin
            opnd_a_q   <= op_a;
            opnd_b_q   <= op_b;
            op_div_q   <= 1'b0;
            wr_q       <= 1'b1;
            div_zero_q <= 1'b0;
            unit_rst_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_CLR;
          end else if (start_div) begin
            busy_q <= 1'b1;
            if (op_b != '0) begin
              opnd_a_q   <= op_a;
              opnd_b_q   <= op_b;
              op_div_q   <= 1'b1;
              wr_q       <= 1'b1;
              div_zero_q <= 1'b0;
              unit_rst_q <= 1'b1;
              state_q    <= S_CLR;
            end else begin
              // Divide by zero skips the unit entirely.
              div_zero_q <= 1'b1;
              wr_q       <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= S_WB;
            end
          end
        end
        S_CLR: begin
          unit_rst_q <= 1'b0;
          cnt_q      <= '0;
          mult_en_q  <= ~op_div_q;
          div_en_q   <= op_div_q;
          state_q    <= S_RUN;
        end
        S_RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == last_d) begin
            mult_en_q <= 1'b0;
            div_en_q  <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_WB;
          end
        end
        S_WB: begin
          if (wr_q) begin
            hi_q <= sel_hi_d;
            lo_q <= sel_lo_d;
          end
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign unit_rst = unit_rst_q;
  assign mult_en  = mult_en_q;
  assign div_en   = div_en_q;
  assign opnd_a   = opnd_a_q;
  assign opnd_b   = opnd_b_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign stall    = busy_q &
    (mfhi_req | mflo_req | start_mult | start_div);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed + random checks of muldiv_ctrl
// against an arithmetic model with mock mult/div units.
module tb_muldiv_ctrl;

  localparam int W    = 32;
  localparam int MULN = 32;
  localparam int DIVN = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_mult, start_div;
  logic [W-1:0] op_a, op_b;
  logic         mfhi_req, mflo_req;
  logic [W-1:0] mult_hi, mult_lo, div_hi, div_lo;
  logic         unit_rst, mult_en, div_en;
  logic [W-1:0] opnd_a, opnd_b, hi_out, lo_out;
  logic         busy, stall, done, div_zero;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] exp_hi, exp_lo;
  logic         exp_dz;

  longint ma, mb, mp;

  always #5 clk = ~clk;

  muldiv_ctrl #(
    .WIDTH(W), .MULT_CYCLES(MULN),
    .DIV_CYCLES(DIVN), .CNT_W(6)
  ) dut (
    .clk(clk), .reset(reset),
    .start_mult(start_mult), .start_div(start_div),
    .op_a(op_a), .op_b(op_b),
    .mfhi_req(mfhi_req), .mflo_req(mflo_req),
    .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_hi(div_hi), .div_lo(div_lo),
    .unit_rst(unit_rst), .mult_en(mult_en),
    .div_en(div_en),
    .opnd_a(opnd_a), .opnd_b(opnd_b),
    .hi_out(hi_out), .lo_out(lo_out),
    .busy(busy), .stall(stall), .done(done),
    .div_zero(div_zero)
  );

  // Mock units: results follow the latched operands.
  always_comb begin
    ma = longint'($signed(opnd_a));
    mb = longint'($signed(opnd_b));
    mp = ma * mb;
    mult_hi = mp[63:32];
    mult_lo = mp[31:0];
    if (mb != 0) begin
      div_lo = 32'(ma / mb);
      div_hi = 32'(ma % mb);
    end else begin
      div_lo = '1;
      div_hi = opnd_a;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model(input int kind,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (kind != 1) begin
      p = sa * sb;
      exp_hi = p[63:32];
      exp_lo = p[31:0];
      exp_dz = 1'b0;
    end else if (b == '0) begin
      exp_dz = 1'b1;
    end else begin
      exp_hi = 32'(sa % sb);
      exp_lo = 32'(sa / sb);
      exp_dz = 1'b0;
    end
  endtask

  // kind: 0 mult, 1 div, 2 both starts together
  task automatic run_op(input int kind,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input bit mf,
                        input bit inj);
    int  c_busy, c_rst, c_men, c_den;
    int  c_done, c_stall, n, e_busy;
    bit  dz, opnd_ok;
    c_busy = 0; c_rst = 0; c_men = 0; c_den = 0;
    c_done = 0; c_stall = 0; opnd_ok = 1'b1;
    dz = (kind == 1) && (b == '0);
    n  = (kind == 1) ? DIVN : MULN;
    e_busy = dz ? 1 : n + 2;
    @(negedge clk);
    start_mult = (kind != 1);
    start_div  = (kind != 0);
    op_a = a;
    op_b = b;
    mfhi_req = mf;
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    for (int i = 0; i < 200 && busy; i++) begin
      c_busy++;
      c_rst   += int'(unit_rst);
      c_men   += int'(mult_en);
      c_den   += int'(div_en);
      c_done  += int'(done);
      c_stall += int'(stall);
      if (!dz && (opnd_a !== a || opnd_b !== b))
        opnd_ok = 1'b0;
      start_mult = inj && (c_men == 5);
      @(negedge clk);
    end
    start_mult = 1'b0;
    model(kind, a, b);
    chk("busy_len", 64'(c_busy), 64'(e_busy));
    chk("busy_end", 64'(busy), 64'(0));
    chk("unit_rst_cnt", 64'(c_rst), 64'(dz ? 0 : 1));
    chk("mult_en_cnt", 64'(c_men),
        64'((kind != 1) ? n : 0));
    chk("div_en_cnt", 64'(c_den),
        64'((kind == 1 && !dz) ? n : 0));
    chk("done_cnt", 64'(c_done), 64'(1));
    if (!dz) chk("opnd_stable", 64'(opnd_ok), 64'(1));
    if (mf) begin
      chk("stall_busy", 64'(c_stall), 64'(e_busy));
      chk("stall_after", 64'(stall), 64'(0));
    end
    chk("hi_out", 64'(hi_out), 64'(exp_hi));
    chk("lo_out", 64'(lo_out), 64'(exp_lo));
    chk("div_zero", 64'(div_zero), 64'(exp_dz));
    mfhi_req = 1'b0;
  endtask

  initial begin
    int c;
    bit seen_done;
    int kind;
    logic [W-1:0] ra, rb;
    reset = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a = '0;
    op_b = '0;
    mfhi_req = 1'b1;
    mflo_req = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    exp_dz = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_hi", 64'(hi_out), 64'(0));
    chk("rst_lo", 64'(lo_out), 64'(0));
    chk("rst_opnd_a", 64'(opnd_a), 64'(0));
    chk("rst_opnd_b", 64'(opnd_b), 64'(0));
    chk("rst_flags",
        64'({unit_rst, mult_en, div_en, done, div_zero}),
        64'(0));
    reset = 1'b0;
    mflo_req = 1'b1;
    @(negedge clk);
    chk("idle_mf_stall", 64'(stall), 64'(0));
    mfhi_req = 1'b0;
    mflo_req = 1'b0;

    run_op(0, 32'd7, -32'sd3, 1'b0, 1'b0);
    chk("mult_hi_ex", 64'(hi_out), 64'h0000_0000_FFFF_FFFF);
    chk("mult_lo_ex", 64'(lo_out), 64'h0000_0000_FFFF_FFEB);
    run_op(1, 32'd17, 32'd5, 1'b0, 1'b0);
    chk("div_hi_ex", 64'(hi_out), 64'd2);
    chk("div_lo_ex", 64'(lo_out), 64'd3);
    run_op(1, 32'd123, 32'd0, 1'b0, 1'b0);
    chk("dz_hi_kept", 64'(hi_out), 64'd2);
    chk("dz_lo_kept", 64'(lo_out), 64'd3);
    run_op(2, 32'hFFFF_FF00, 32'd77, 1'b0, 1'b0);
    run_op(0, $urandom, $urandom, 1'b1, 1'b1);

    @(negedge clk);
    start_mult = 1'b1;
    op_a = $urandom;
    op_b = $urandom;
    @(negedge clk);
    start_mult = 1'b0;
    c = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 100 && c < 10; i++) begin
      c += int'(mult_en);
      seen_done |= done;
      if (c < 10) @(negedge clk);
    end
    chk("rrun_reached", 64'(c), 64'(10));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    exp_dz = 1'b0;
    chk("rrun_busy", 64'(busy), 64'(0));
    chk("rrun_en", 64'({mult_en, div_en, unit_rst}), 64'(0));
    chk("rrun_done", 64'({seen_done, done}), 64'(0));
    chk("rrun_hi", 64'(hi_out), 64'(0));
    chk("rrun_lo", 64'(lo_out), 64'(0));
    @(negedge clk);
    chk("rrun_idle", 64'({busy, done}), 64'(0));

    for (int k = 0; k < 8; k++) begin
      kind = int'($urandom_range(0, 2));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      run_op(kind, ra, rb, bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
